uart_cmd_decoder: RTL and testbench

- Consumes the byte stream from the UART receiver (one-cycle valid pulse plus byte) and parses fixed 5-byte command frames.
- Issues single-cycle register write/read strobes to a local register bank.
- Returns a one-byte response to the UART transmitter over a valid/ready handshake.
- Sits between uart_rx and uart_tx in the top level.

---
 rtl/uart_cmd_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses 5-byte command frames (HEADER CMD ADDR DATA CHK)
// from the UART receiver, issues register write/read strobes and returns a
// one-byte response to the UART transmitter.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | hunting for the header byte, everything else dropped
//   CMD    | waiting for the command byte
//   ADDR   | waiting for the address byte
//   DATA   | waiting for the data byte
//   CHK    | waiting for the checksum byte
//   EXEC   | one cycle: validate frame, fire write/read strobe or NAK
//   RDWAIT | one cycle: capture register read data as the response
//   RESP   | presenting the response byte until the transmitter takes it
module uart_cmd_decoder #(
  parameter logic [7:0]  HeaderByte    = 8'h55,
  parameter int unsigned TimeoutCycles = 10_000,
  parameter logic [7:0]  AckByte       = 8'hAC,
  parameter logic [7:0]  NakByte       = 8'h15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_en,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_byte,
  output logic       o_err_pulse,
  output logic [7:0] o_err_cnt
);

  localparam logic [7:0] CmdWrite = 8'h01;
  localparam logic [7:0] CmdRead  = 8'h02;

  // The idle cycle that would take the count to TimeoutCycles-1 is the one
  // that aborts the frame, so compare against the value one below it.
  localparam logic [23:0] TmoLast = 24'(TimeoutCycles - 32'd2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EXEC,
    S_RDWAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  chk_q, chk_d;
  logic [23:0] tmo_q, tmo_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic wr_en;
  logic rd_en;
  logic tx_valid;
  logic err_pulse;
  logic frame_ok;

  // Checksum and command legality of the frame currently held in the capture registers.
  always_comb begin
    frame_ok = (chk_q == (cmd_q ^ addr_q ^ data_q)) &&
               ((cmd_q == CmdWrite) || (cmd_q == CmdRead));
  end

  // Next-state, capture, timeout and strobe/response logic.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    chk_d     = chk_q;
    tmo_d     = '0;
    tx_byte_d = tx_byte_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    tx_valid  = 1'b0;
    err_pulse = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_byte == HeaderByte)) begin
          state_d = S_CMD;
        end
      end

      S_CMD, S_ADDR, S_DATA, S_CHK: begin
        if (i_rx_valid) begin
          unique case (state_q)
            S_CMD:   begin cmd_d  = i_rx_byte; state_d = S_ADDR; end
            S_ADDR:  begin addr_d = i_rx_byte; state_d = S_DATA; end
            S_DATA:  begin data_d = i_rx_byte; state_d = S_CHK;  end
            default: begin chk_d  = i_rx_byte; state_d = S_EXEC; end
          endcase
        end else if (tmo_q == TmoLast) begin
          state_d   = S_IDLE;
          err_pulse = 1'b1;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end

      S_EXEC: begin
        err_pulse = i_rx_valid;
        if (!frame_ok) begin
          tx_byte_d = NakByte;
          err_pulse = 1'b1;
          state_d   = S_RESP;
        end else if (cmd_q == CmdWrite) begin
          wr_en     = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
          tx_byte_d = AckByte;
          state_d   = S_RESP;
        end else begin
          rd_en     = 1'b1;
          rd_addr_d = addr_q;
          state_d   = S_RDWAIT;
        end
      end

      S_RDWAIT: begin
        err_pulse = i_rx_valid;
        tx_byte_d = i_rd_data;
        state_d   = S_RESP;
      end

      S_RESP: begin
        err_pulse = i_rx_valid;
        tx_valid  = 1'b1;
        if (i_tx_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Saturating frame-error counter.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_pulse && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      tx_byte_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      tx_byte_q <= tx_byte_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // The _d values equal the captured frame during a strobe and the held
  // value otherwise, so address/data are valid alongside the strobe.
  assign o_wr_en     = wr_en;
  assign o_wr_addr   = wr_addr_d;
  assign o_wr_data   = wr_data_d;
  assign o_rd_en     = rd_en;
  assign o_rd_addr   = rd_addr_d;
  assign o_tx_valid  = tx_valid;
  assign o_tx_byte   = tx_byte_q;
  assign o_err_pulse = err_pulse;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: write/read/error frames, junk
// rejection, inter-byte timeout, response backpressure and reset.
module tb_uart_cmd_decoder;

  logic       clk;
  logic       i_rst_n;
  logic       i_rx_valid;
  logic [7:0] i_rx_byte;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_rd_en;
  logic [7:0] o_rd_addr;
  logic [7:0] i_rd_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [7:0] o_tx_byte;
  logic       o_err_pulse;
  logic [7:0] o_err_cnt;

  int vectors     = 0;
  int miscompares = 0;

  int wr_seen  = 0;
  int tx_seen  = 0;
  int err_seen = 0;
  int wr_base, tx_base, err_base;

  uart_cmd_decoder #(
    .HeaderByte   (8'h55),
    .TimeoutCycles(50),
    .AckByte      (8'hAC),
    .NakByte      (8'h15)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_rx_valid (i_rx_valid),
    .i_rx_byte  (i_rx_byte),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_tx_byte  (o_tx_byte),
    .o_err_pulse(o_err_pulse),
    .o_err_cnt  (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, read back only after the following edge.
  always @(negedge clk) begin
    if (o_wr_en) wr_seen <= wr_seen + 1;
    if (o_tx_valid && i_tx_ready) tx_seen <= tx_seen + 1;
    if (o_err_pulse) err_seen <= err_seen + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One-cycle receive pulse; returns 1 time unit after the capturing edge.
  task automatic send(input logic [7:0] b);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic snapshot;
    wr_base  = wr_seen;
    tx_base  = tx_seen;
    err_base = err_seen;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_byte  = 8'h00;
    i_rd_data  = 8'h00;
    i_tx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk8("rst_ctrl", {4'd0, o_wr_en, o_rd_en, o_tx_valid, o_err_pulse}, 8'h00);
    chk8("rst_tx_byte", o_tx_byte, 8'h00);
    chk8("rst_err_cnt", o_err_cnt, 8'h00);
    chk8("rst_wr_addr", o_wr_addr, 8'h00);
    step();
    i_rst_n = 1'b1;
    step();

    // Write 55 01 10 3C 2D
    snapshot();
    send(8'h55); send(8'h01); send(8'h10); send(8'h3C); send(8'h2D);
    @(negedge clk);
    chk1("wr_en", o_wr_en, 1'b1);
    chk8("wr_addr", o_wr_addr, 8'h10);
    chk8("wr_data", o_wr_data, 8'h3C);
    chk1("wr_tx_early", o_tx_valid, 1'b0);
    @(negedge clk);
    chk1("wr_tx_valid", o_tx_valid, 1'b1);
    chk8("wr_tx_byte", o_tx_byte, 8'hAC);
    chk1("wr_en_once", o_wr_en, 1'b0);
    @(negedge clk);
    chk1("wr_tx_drop", o_tx_valid, 1'b0);
    chk8("wr_err_cnt", o_err_cnt, 8'h00);
    step();
    chkn("wr_strobes", wr_seen - wr_base, 1);

    // Read 55 02 20 00 22, register returns 5A in RDWAIT only
    snapshot();
    send(8'h55); send(8'h02); send(8'h20); send(8'h00); send(8'h22);
    @(negedge clk);
    chk1("rd_en", o_rd_en, 1'b1);
    chk8("rd_addr", o_rd_addr, 8'h20);
    chk1("rd_no_wr", o_wr_en, 1'b0);
    step();
    i_rd_data = 8'h5A;
    @(negedge clk);
    chk1("rd_en_once", o_rd_en, 1'b0);
    chk1("rd_tx_early", o_tx_valid, 1'b0);
    step();
    i_rd_data = 8'h00;
    @(negedge clk);
    chk1("rd_tx_valid", o_tx_valid, 1'b1);
    chk8("rd_tx_byte", o_tx_byte, 8'h5A);
    @(negedge clk);
    chk1("rd_tx_drop", o_tx_valid, 1'b0);
    step();
    chkn("rd_no_wr_total", wr_seen - wr_base, 0);
    chkn("rd_tx_count", tx_seen - tx_base, 1);

    // Junk then frame: 00 AA 55 01 05 07 03
    snapshot();
    send(8'h00); send(8'hAA);
    send(8'h55); send(8'h01); send(8'h05); send(8'h07); send(8'h03);
    @(negedge clk);
    chk1("junk_wr_en", o_wr_en, 1'b1);
    chk8("junk_wr_addr", o_wr_addr, 8'h05);
    chk8("junk_wr_data", o_wr_data, 8'h07);
    chk1("junk_no_err", o_err_pulse, 1'b0);
    @(negedge clk);
    chk1("junk_tx_valid", o_tx_valid, 1'b1);
    chk8("junk_tx_byte", o_tx_byte, 8'hAC);
    @(negedge clk);
    step();
    chkn("junk_err_count", err_seen - err_base, 0);

    // Timeout (50): 48 idle cycles are tolerated, the 49th aborts the frame
    snapshot();
    send(8'h55);
    repeat (48) step();
    send(8'h01);
    repeat (48) @(negedge clk);
    chk1("tmo_not_yet", o_err_pulse, 1'b0);
    chkn("tmo_no_early_err", err_seen - err_base, 0);
    @(negedge clk);
    chk1("tmo_err_pulse", o_err_pulse, 1'b1);
    chk1("tmo_no_tx", o_tx_valid, 1'b0);
    @(negedge clk);
    chk1("tmo_pulse_once", o_err_pulse, 1'b0);
    step();
    chkn("tmo_err_count", err_seen - err_base, 1);
    chkn("tmo_tx_count", tx_seen - tx_base, 0);
    chk8("tmo_err_cnt", o_err_cnt, 8'h01);
    send(8'h55); send(8'h01); send(8'h33); send(8'h44); send(8'h76);
    @(negedge clk);
    chk1("post_tmo_wr_en", o_wr_en, 1'b1);
    chk8("post_tmo_wr_addr", o_wr_addr, 8'h33);
    chk8("post_tmo_wr_data", o_wr_data, 8'h44);
    @(negedge clk);
    chk8("post_tmo_tx_byte", o_tx_byte, 8'hAC);
    @(negedge clk);
    step();

    // Backpressure: 20 RESP cycles with ready low, stray header mid-way
    i_tx_ready = 1'b0;
    send(8'h55); send(8'h01); send(8'h22); send(8'h99); send(8'hBA);
    @(negedge clk);
    chk1("bp_wr_en", o_wr_en, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      i_rx_valid = (i == 10);
      i_rx_byte  = 8'h55;
      @(negedge clk);
      chk1("bp_tx_valid", o_tx_valid, 1'b1);
      chk8("bp_tx_byte", o_tx_byte, 8'hAC);
      if (i == 10) chk1("bp_stray_err", o_err_pulse, 1'b1);
    end
    step();
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    @(negedge clk);
    chk1("bp_tx_complete", o_tx_valid, 1'b1);
    @(negedge clk);
    chk1("bp_tx_drop", o_tx_valid, 1'b0);
    chk1("bp_no_wr", o_wr_en, 1'b0);
    chk8("bp_err_cnt", o_err_cnt, 8'h02);
    step();

    // Bad checksum 55 01 10 3C 00
    snapshot();
    send(8'h55); send(8'h01); send(8'h10); send(8'h3C); send(8'h00);
    @(negedge clk);
    chk1("bad_no_wr", o_wr_en, 1'b0);
    chk1("bad_err_pulse", o_err_pulse, 1'b1);
    @(negedge clk);
    chk1("bad_tx_valid", o_tx_valid, 1'b1);
    chk8("bad_tx_byte", o_tx_byte, 8'h15);
    @(negedge clk);
    chk8("bad_err_cnt", o_err_cnt, 8'h03);
    chk8("bad_wr_addr_held", o_wr_addr, 8'h22);
    step();
    for (int n = 0; n < 297; n++) begin
      send(8'h55); send(8'h01); send(8'h10); send(8'h3C); send(8'h00);
      repeat (3) step();
    end
    chk8("sat_err_cnt", o_err_cnt, 8'hFF);
    chkn("sat_no_wr", wr_seen - wr_base, 0);
    chkn("sat_tx_count", tx_seen - tx_base, 298);

    // Reset after the ADDR byte, then an orphan DATA+CHK
    send(8'h55); send(8'h01); send(8'h10);
    i_rst_n = 1'b0;
    #2;
    chk8("mid_rst_ctrl", {4'd0, o_wr_en, o_rd_en, o_tx_valid, o_err_pulse}, 8'h00);
    chk8("mid_rst_tx_byte", o_tx_byte, 8'h00);
    chk8("mid_rst_err_cnt", o_err_cnt, 8'h00);
    chk8("mid_rst_wr_addr", o_wr_addr, 8'h00);
    chk8("mid_rst_rd_addr", o_rd_addr, 8'h00);
    step();
    i_rst_n = 1'b1;
    step();
    snapshot();
    send(8'h3C); send(8'h2D);
    repeat (6) step();
    chkn("orphan_no_wr", wr_seen - wr_base, 0);
    chkn("orphan_no_tx", tx_seen - tx_base, 0);
    chkn("orphan_no_err", err_seen - err_base, 0);
    send(8'h55); send(8'h01); send(8'h10); send(8'h3C); send(8'h2D);
    @(negedge clk);
    chk1("post_rst_wr_en", o_wr_en, 1'b1);
    chk8("post_rst_wr_data", o_wr_data, 8'h3C);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
